// File: rtl/i_cache_refill.sv
// Miss queue and line-refill engine for i_cache: collects lane misses with
// duplicate suppression, reads one line per miss and presents it as a fill.
module i_cache_refill #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LINE_SIZE   = 2,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                miss_valid,
    input  logic [ADDR_WIDTH-1:0]     miss_addr [2],
    input  logic                      ext_flush,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [31:0]               mem_resp_data,
    output logic [ADDR_WIDTH-1:0]     fetch_addr,
    output logic                      fetch_addr_valid,
    output logic [32*LINE_SIZE-1:0]   fetched_data,
    output logic                      queue_full,
    output logic                      busy
);
    localparam int unsigned OFF = 2 + $clog2(LINE_SIZE);
    localparam int unsigned PW  = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned BW  = $clog2(LINE_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};

    typedef enum logic [1:0] {IDLE, REQ, RESP, WRITE} state_t;
    state_t state, state_next;

    logic [ADDR_WIDTH-1:0]  queue [QUEUE_DEPTH];
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count;
    logic [ADDR_WIDTH-1:0]  cur_line;
    logic [BW-1:0]          beat;
    logic [31:0]            line_buf [LINE_SIZE];

    logic [ADDR_WIDTH-1:0]  line0, line1;
    logic [QUEUE_DEPTH-1:0] slot_valid;
    logic                   dup0, dup1, push0, push1, pop, last_beat;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        slot_valid = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            slot_valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
        end
    end

    always_comb begin
        line0 = miss_addr[0] & LINE_MASK;
        line1 = miss_addr[1] & LINE_MASK;
        dup0  = (state != IDLE) && (line0 == cur_line);
        dup1  = ((state != IDLE) && (line1 == cur_line)) || (miss_valid[0] && (line1 == line0));
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            if (slot_valid[i] && (queue[i] == line0)) dup0 = 1'b1;
            if (slot_valid[i] && (queue[i] == line1)) dup1 = 1'b1;
        end
        push0 = !ext_flush && miss_valid[0] && !dup0 && (count < CW'(QUEUE_DEPTH));
        push1 = !ext_flush && miss_valid[1] && !dup1 &&
                ((count + CW'(push0)) < CW'(QUEUE_DEPTH));
        pop       = (state == IDLE) && (count != '0) && !ext_flush;
        last_beat = mem_resp_valid && (beat == BW'(LINE_SIZE - 1));
    end

    always_comb begin
        state_next       = state;
        mem_req_valid    = 1'b0;
        fetch_addr_valid = 1'b0;
        case (state)
            IDLE:  if (pop) state_next = REQ;
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = RESP;
            end
            RESP:  if (last_beat) state_next = WRITE;
            WRITE: begin
                fetch_addr_valid = 1'b1;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_req_addr = cur_line;
    assign queue_full   = count >= CW'(QUEUE_DEPTH - 1);
    assign busy         = (state != IDLE) || (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) queue[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push0) queue[wr_ptr] <= line0;
            if (push1) queue[wr_ptr + PW'(push0)] <= line1;
            if (ext_flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
                rd_ptr <= rd_ptr + PW'(pop);
                count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
            end
        end
    end

    // Fill outputs are captured on the last beat so they hold between fills.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_line <= '0;
            beat     <= '0;
            for (int unsigned i = 0; i < LINE_SIZE; i++) line_buf[i] <= '0;
            fetch_addr   <= '0;
            fetched_data <= '0;
        end else begin
            case (state)
                IDLE: if (pop) cur_line <= queue[rd_ptr];
                REQ:  if (mem_req_ready) beat <= '0;
                RESP: if (mem_resp_valid) begin
                    line_buf[beat] <= mem_resp_data;
                    beat           <= beat + 1'b1;
                    if (last_beat) begin
                        fetch_addr <= cur_line;
                        for (int unsigned i = 0; i < LINE_SIZE; i++) begin
                            fetched_data[32*i +: 32] <= (BW'(i) == beat) ? mem_resp_data : line_buf[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i_cache_refill.sv
// Scoreboard bench for i_cache_refill: a queue-based reference model predicts
// per-cycle status, requests and fills; a monitor compares at the falling edge.
module tb_i_cache_refill;
    localparam int unsigned AW = 32;
    localparam int unsigned LS = 2;
    localparam int unsigned QD = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      miss_valid;
    logic [AW-1:0]   miss_addr [2];
    logic            ext_flush;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_resp_valid;
    logic [31:0]     mem_resp_data;
    logic [AW-1:0]   fetch_addr;
    logic            fetch_addr_valid;
    logic [32*LS-1:0] fetched_data;
    logic            queue_full;
    logic            busy;

    always #5 clk = ~clk;

    i_cache_refill #(.ADDR_WIDTH(AW), .LINE_SIZE(LS), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
        .ext_flush(ext_flush), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fetch_addr(fetch_addr), .fetch_addr_valid(fetch_addr_valid), .fetched_data(fetched_data),
        .queue_full(queue_full), .busy(busy)
    );

    typedef struct { bit rv; bit fv; bit bz; bit fl; } status_t;

    int compared = 0;
    int mismatched = 0;

    status_t         status_q [$];
    logic [AW-1:0]   req_q [$];
    logic [AW-1:0]   fill_addr_q [$];
    logic [32*LS-1:0] fill_data_q [$];
    logic [31:0]     resp_words [$];
    bit              mon_en = 1'b0;

    // Reference model: pending lines, the line being serviced and its progress
    // (0 nothing, 1 asking memory, 2 collecting words, 3 presenting the fill).
    logic [AW-1:0]   mq [$];
    int              stage = 0;
    logic [AW-1:0]   cur = '0;
    int              got = 0;
    logic [31:0]     words [LS];

    bit              req_active = 1'b0;
    logic [AW-1:0]   exp_req = '0;
    logic [AW-1:0]   last_fa = '0;
    logic [32*LS-1:0] last_fd = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_event(string name, logic [63:0] act);
        compared++;
        mismatched++;
        $display("FAIL %s: got %h expected none at %0t", name, act, $time);
    endfunction

    function automatic logic [AW-1:0] line_of(logic [AW-1:0] a);
        return (a / (4 * LS)) * (4 * LS);
    endfunction

    function automatic bit in_model(logic [AW-1:0] l);
        foreach (mq[i]) if (mq[i] == l) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle(input bit mv0, input logic [AW-1:0] a0, input bit mv1,
                         input logic [AW-1:0] a1, input bit fl, input bit rdy, input bit rv);
        status_t st;
        logic [31:0] d;
        logic [AW-1:0] l0, l1;
        logic [AW-1:0] nq [$];
        logic [32*LS-1:0] fd;
        bit popping;
        @(posedge clk); #1;
        st.rv = (stage == 1);
        st.fv = (stage == 3);
        st.bz = (stage != 0) || (mq.size() != 0);
        st.fl = (mq.size() >= QD - 1);
        status_q.push_back(st);
        mon_en = 1'b1;
        if (stage == 2 && rv && resp_words.size() != 0) d = resp_words.pop_front();
        else d = $urandom();
        miss_valid     = {mv1, mv0};
        miss_addr[0]   = a0;
        miss_addr[1]   = a1;
        ext_flush      = fl;
        mem_req_ready  = rdy;
        mem_resp_valid = rv;
        mem_resp_data  = d;
        l0 = line_of(a0);
        l1 = line_of(a1);
        popping = (stage == 0) && (mq.size() != 0) && !fl;
        if (!fl) begin
            if (mv0 && !in_model(l0) && !(stage != 0 && l0 == cur) && mq.size() < QD)
                nq.push_back(l0);
            if (mv1 && !in_model(l1) && !(stage != 0 && l1 == cur) && !(mv0 && l1 == l0) &&
                mq.size() + nq.size() < QD)
                nq.push_back(l1);
        end
        case (stage)
            0: if (popping) begin
                cur = mq.pop_front();
                req_q.push_back(cur);
                stage = 1;
            end
            1: if (rdy) begin
                stage = 2;
                got = 0;
            end
            2: if (rv) begin
                words[got] = d;
                if (got == LS - 1) begin
                    for (int i = 0; i < LS; i++) fd[32*i +: 32] = words[i];
                    fill_addr_q.push_back(cur);
                    fill_data_q.push_back(fd);
                    stage = 3;
                end else got++;
            end
            default: stage = 0;
        endcase
        if (fl) mq.delete();
        else foreach (nq[i]) mq.push_back(nq[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_req_addr"}, mem_req_addr, 0);
        check({tag, "_fetch_valid"}, fetch_addr_valid, 0);
        check({tag, "_fetch_addr"}, fetch_addr, 0);
        check({tag, "_fetched_data"}, fetched_data, 0);
        check({tag, "_queue_full"}, queue_full, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        status_t st;
        forever begin
            @(negedge clk);
            if (reset) begin
                req_active = 1'b0;
                last_fa = '0;
                last_fd = '0;
            end else if (mon_en) begin
                if (status_q.size() == 0) fail_event("status_underflow", 0);
                else begin
                    st = status_q.pop_front();
                    check("mem_req_valid", mem_req_valid, st.rv);
                    check("fetch_addr_valid", fetch_addr_valid, st.fv);
                    check("busy", busy, st.bz);
                    check("queue_full", queue_full, st.fl);
                end
                if (mem_req_valid) begin
                    if (!req_active) begin
                        if (req_q.size() == 0) fail_event("unexpected_request", mem_req_addr);
                        else exp_req = req_q.pop_front();
                        req_active = 1'b1;
                    end
                    check("mem_req_addr", mem_req_addr, exp_req);
                    if (mem_req_ready) req_active = 1'b0;
                end
                if (fetch_addr_valid) begin
                    if (fill_addr_q.size() == 0) fail_event("unexpected_fill", fetch_addr);
                    else begin
                        last_fa = fill_addr_q.pop_front();
                        last_fd = fill_data_q.pop_front();
                    end
                end
                check("fetch_addr", fetch_addr, last_fa);
                check("fetched_data", fetched_data, last_fd);
            end
        end
    end

    initial begin
        logic [AW-1:0] a0, a1;
        reset = 1'b1;
        miss_valid = '0;
        miss_addr[0] = '0;
        miss_addr[1] = '0;
        ext_flush = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Single miss with zero-wait memory: request in N+2, fill in N+5.
        resp_words = {32'hAAAA0001, 32'hBBBB0002};
        cycle(1'b1, 32'h1004, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("single_req_valid", mem_req_valid, 1);
        check("single_req_addr", mem_req_addr, 32'h1000);
        idle(3);
        check("single_fill_valid", fetch_addr_valid, 1);
        check("single_fill_addr", fetch_addr, 32'h1000);
        check("single_fill_data", fetched_data, 64'hBBBB0002_AAAA0001);
        idle(2);

        // Both lanes on the same line.
        cycle(1'b1, 32'h2000, 1'b1, 32'h2004, 1'b0, 1'b1, 1'b1);
        idle(8);

        // Stalled memory fills the queue; extra misses are dropped.
        for (int i = 1; i <= 7; i++) cycle(1'b1, AW'(i * 256), 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("stall_queue_full", queue_full, 1);
        check("stall_req_addr", mem_req_addr, 32'h100);
        idle(40);

        // Flush during the response phase of 0x3000 with two lines queued.
        cycle(1'b1, 32'h3000, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h4000, 1'b1, 32'h5000, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(3);
        check("flush_busy_after_write", busy, 0);
        idle(4);

        // Asynchronous reset in the middle of a response.
        cycle(1'b1, 32'h6000, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        #2;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        mq.delete();
        stage = 0;
        cur = '0;
        status_q.delete();
        req_q.delete();
        fill_addr_q.delete();
        fill_data_q.delete();
        resp_words.delete();
        miss_valid = '0;
        ext_flush = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(1'b1, 32'h7008, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(8);

        // Randomized traffic over a small line pool to provoke duplicates.
        for (int k = 0; k < 1500; k++) begin
            a0 = AW'($urandom_range(0, 95));
            a1 = ($urandom_range(0, 3) == 0) ? (a0 ^ 32'h4) : AW'($urandom_range(0, 95));
            cycle($urandom_range(0, 2) == 0, a0, $urandom_range(0, 2) == 0, a1,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0);
        end

        for (int k = 0; k < 200 && (stage != 0 || mq.size() != 0); k++) idle(1);
        idle(2);
        if (stage != 0 || mq.size() != 0) fail_event("drain_timeout", 64'(stage));
        @(negedge clk);
        #1;
        check("leftover_requests", req_q.size(), 0);
        check("leftover_fills", fill_addr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
